// File: rtl/serdes_rx_framer.sv
// Serial frame receiver (start=1, DATA_W data, optional even parity, stop=0) feeding a FWFT FIFO.
// Define SERDES_PARITY_EN to insert and check the parity bit between data and stop.
module serdes_rx_framer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          ser_in,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                ferr_q, ferr_d;
  logic                wr_req;
  logic                par_ok;
`ifdef SERDES_PARITY_EN
  logic                par_q, par_d;
  assign par_ok = (par_q == ^shift_q);
`else
  assign par_ok = 1'b1;
`endif

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      cnt_q;
  logic                ovf_q;
  logic                full, pop, wr_ok;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    wr_req    = 1'b0;
`ifdef SERDES_PARITY_EN
    par_d     = par_q;
`endif
    if (ena) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          if (ser_in) state_d = DATA;
        end
        DATA: begin
          if (LSB_FIRST != 0) shift_d = {ser_in, shift_q[DATA_W-1:1]};
          else                shift_d = {shift_q[DATA_W-2:0], ser_in};
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            bit_cnt_d = '0;
`ifdef SERDES_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
`ifdef SERDES_PARITY_EN
          par_d   = ser_in;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          wr_req  = !ser_in && par_ok;
          ferr_d  = !(!ser_in && par_ok);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef SERDES_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
`ifdef SERDES_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // A pop on the same edge frees the slot, so a write to a full FIFO still lands.
  assign full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop   = rd_en && (cnt_q != '0);
  assign wr_ok = wr_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (wr_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign rd_valid   = (cnt_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_serdes_rx_framer.sv
// Bench for serdes_rx_framer: LSB-first and MSB-first instances receive the same words in lockstep.
module tb_serdes_rx_framer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, rd_en = 1'b0;
  logic ser_in = 1'b0, ser_in_m = 1'b0;
  logic [DW-1:0] rd_data, rd_data_m;
  logic rd_valid, rd_valid_m, overflow, overflow_m, frame_err, frame_err_m;
  logic [2:0] fifo_count, fifo_count_m;

  int cmp_cnt = 0, err_cnt = 0;
  logic [DW-1:0] exp_q[$];
  int   m_cnt = 0;
  logic m_ovf = 1'b0;

  always #5 clk = ~clk;

  serdes_rx_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ser_in(ser_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err));

  serdes_rx_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ser_in(ser_in_m), .rd_en(rd_en),
    .rd_data(rd_data_m), .rd_valid(rd_valid_m), .fifo_count(fifo_count_m),
    .overflow(overflow_m), .frame_err(frame_err_m));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    logic [DW-1:0] head;
    head = (m_cnt != 0) ? exp_q[0] : '0;
    check({tag, ".cnt"},     fifo_count,   m_cnt);
    check({tag, ".cnt_m"},   fifo_count_m, m_cnt);
    check({tag, ".vld"},     rd_valid,     m_cnt != 0);
    check({tag, ".vld_m"},   rd_valid_m,   m_cnt != 0);
    check({tag, ".ovf"},     overflow,     m_ovf);
    check({tag, ".ovf_m"},   overflow_m,   m_ovf);
    check({tag, ".head"},    rd_data,      head);
    check({tag, ".head_m"},  rd_data_m,    head);
  endtask

  task automatic pop_word(input string tag);
    check_status(tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (m_cnt > 0) begin
      exp_q.delete(0);
      m_cnt--;
    end
  endtask

  task automatic send_bit(input logic b, input logic bm);
    ser_in   = b;
    ser_in_m = bm;
    tick();
  endtask

  // pause_after: number of data bits sent before a 3-cycle ena=0 gap (-1 = none)
  task automatic send_frame(input logic [DW-1:0] w, input logic stop, input logic par_flip,
                            input int pause_after, input logic pop_at_stop);
    logic bad;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < DW; i++) begin
      if (i == pause_after) begin
        ena      = 1'b0;
        ser_in   = ~w[i];
        ser_in_m = ~w[DW-1-i];
        repeat (3) tick();
        ena = 1'b1;
      end
      send_bit(w[i], w[DW-1-i]);
    end
`ifdef SERDES_PARITY_EN
    send_bit((^w) ^ par_flip, (^w) ^ par_flip);
    bad = stop | par_flip;
`else
    bad = stop;
`endif
    ser_in   = stop;
    ser_in_m = stop;
    if (pop_at_stop) begin
      check_status("pop_at_stop");
      rd_en = 1'b1;
    end
    tick();
    rd_en = 1'b0; ser_in = 1'b0; ser_in_m = 1'b0;
    if (pop_at_stop && m_cnt > 0) begin
      exp_q.delete(0);
      m_cnt--;
    end
    if (!bad) begin
      if (m_cnt < DEPTH) begin
        exp_q.push_back(w);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    check("frame_err",   frame_err,   bad);
    check("frame_err_m", frame_err_m, bad);
    if (bad) begin
      tick();
      check("frame_err_end",   frame_err,   1'b0);
      check("frame_err_end_m", frame_err_m, 1'b0);
    end
  endtask

  initial begin
    repeat (2) tick();
    check_status("reset");
    check("reset.ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // single frame, then pop back to empty
    send_frame(8'hAA, 1'b0, 1'b0, -1, 1'b0);
    check_status("one");
    pop_word("one_pop");
    check_status("one_empty");

    // five frames into a 4-deep FIFO: last dropped, overflow sticky
    foreach (exp_q[i]) ;
    send_frame(8'hAA, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'hCC, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, -1, 1'b0);
    check_status("full");
    check("full.ovf_const", overflow, 1'b1);
    for (int i = 0; i < 4; i++) pop_word("drain");
    check_status("drained");

    // bad stop bit
    send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
    check_status("badstop");

    // enable gap mid-frame
    send_frame(8'hC3, 1'b0, 1'b0, 4, 1'b0);
    check_status("ena_gap");
    check("ena_gap.lsb", rd_data,   8'hC3);
    check("ena_gap.msb", rd_data_m, 8'hC3);
    pop_word("ena_gap_pop");

    // reset in the middle of a frame
    send_frame(8'h77, 1'b0, 1'b0, -1, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    rst_n = 1'b0;
    ser_in = 1'b0; ser_in_m = 1'b0;
    exp_q.delete(); m_cnt = 0; m_ovf = 1'b0;
    #1;
    check_status("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h0F, 1'b0, 1'b0, -1, 1'b0);
    check_status("after_rst");
    pop_word("after_rst_pop");

    // simultaneous pop and write while full
    send_frame(8'h01, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h04, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0, -1, 1'b1);
    check_status("full_rw");
    for (int i = 0; i < 4; i++) pop_word("full_rw_drain");

    // simultaneous pop and write with one entry
    send_frame(8'h06, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0, -1, 1'b1);
    check_status("one_rw");
    pop_word("one_rw_pop");

`ifdef SERDES_PARITY_EN
    send_frame(8'hAA, 1'b0, 1'b1, -1, 1'b0);
    check_status("par_bad");
`endif

    // random traffic exercising pointer wrap
    for (int n = 0; n < 12; n++) begin
      send_frame(DW'($urandom_range(0, 255)), 1'b0, 1'b0, -1, 1'b0);
      if ($urandom_range(0, 2) != 0 && m_cnt > 0) pop_word("rnd_pop");
      check_status("rnd");
    end
    while (m_cnt > 0) pop_word("final_drain");
    check_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
